// File: rtl/gol_pkg.sv
// Shared types for the game-of-life board engine: row type, sequencer states, board size.
package gol_pkg;
  localparam int BOARD_ROWS = 8;

  typedef logic [7:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    WRITE,
    DONE
  } seq_state_t;
endpackage

// File: rtl/decoder_top.sv
// Next-generation row for an 8-cell toroidal row given the rows above and below.
module decoder_top
  import gol_pkg::*;
(
  input  row_t row_in,
  input  row_t row_a,
  input  row_t row_b,
  output row_t row_out
);

  for (genvar i = 0; i < 8; i++) begin : g_cell
    localparam int L = (i + 7) % 8;
    localparam int R = (i + 1) % 8;
    logic [3:0] w_n;
    assign w_n = 4'(row_a[L]) + 4'(row_a[i]) + 4'(row_a[R]) +
                 4'(row_in[L]) + 4'(row_in[R]) +
                 4'(row_b[L]) + 4'(row_b[i]) + 4'(row_b[R]);
    assign row_out[i] = (w_n == 4'd3) | (row_in[i] & (w_n == 4'd2));
  end

endmodule

// File: rtl/gen_sequencer.sv
// Generation write-side engine: loads the board into a shadow, then writes the next
// generation back in place, row by row, under a grant that may be withdrawn at any time.
module gen_sequencer
  import gol_pkg::*;
#(
  parameter int ROWS   = BOARD_ROWS,
  parameter int ADDR_W = 3,
  parameter int GEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              extinct,
  output logic [GEN_W-1:0]  gen_count,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);

  seq_state_t          r_state, w_next;
  logic [ADDR_W:0]     r_ptr;
  logic [ADDR_W-1:0]   w_ptr_lo, w_ptr_up, w_ptr_dn;
  row_t                r_shadow [ROWS];
  row_t                w_new_row;
  logic                r_rd_vld_p1;
  logic [ADDR_W-1:0]   r_rd_addr_p1;
  row_t                r_acc;
  logic                r_extinct;
  logic [GEN_W-1:0]    r_gen;

  assign w_ptr_lo = r_ptr[ADDR_W-1:0];
  assign w_ptr_up = w_ptr_lo - ADDR_W'(1);
  assign w_ptr_dn = w_ptr_lo + ADDR_W'(1);

  decoder_top u_decoder (
    .row_in  (r_shadow[w_ptr_lo]),
    .row_a   (r_shadow[w_ptr_up]),
    .row_b   (r_shadow[w_ptr_dn]),
    .row_out (w_new_row)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // LOAD is left on the capture of the last row, not on its issue.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = REQ;
      REQ:     if (mem_gnt) w_next = LOAD;
      LOAD:    if (r_rd_vld_p1 && (r_rd_addr_p1 == LAST)) w_next = WRITE;
      WRITE:   if (mem_gnt && (w_ptr_lo == LAST)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
    mem_req = (r_state == REQ) || (r_state == LOAD) || (r_state == WRITE);
    rd_en   = (r_state == LOAD) && mem_gnt && !r_ptr[ADDR_W];
    wr_en   = (r_state == WRITE) && mem_gnt;
    rd_addr = rd_en ? w_ptr_lo : '0;
    wr_addr = wr_en ? w_ptr_lo : '0;
    wr_data = wr_en ? w_new_row : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_addr_p1 <= '0;
      r_acc        <= '0;
      r_extinct    <= 1'b0;
      r_gen        <= '0;
      for (int i = 0; i < ROWS; i++) r_shadow[i] <= '0;
    end else begin
      // p1: read data returns one cycle after the strobe, independent of the grant
      r_rd_vld_p1  <= rd_en;
      r_rd_addr_p1 <= rd_addr;
      if (r_rd_vld_p1) r_shadow[r_rd_addr_p1] <= rd_data;

      case (r_state)
        IDLE: begin
          r_ptr <= '0;
          if (start) r_acc <= '0;
        end
        REQ: r_ptr <= '0;
        LOAD: begin
          if (w_next == WRITE) r_ptr <= '0;
          else if (rd_en)      r_ptr <= r_ptr + (ADDR_W+1)'(1);
        end
        WRITE: begin
          if (wr_en) begin
            r_ptr <= (w_ptr_lo == LAST) ? '0 : r_ptr + (ADDR_W+1)'(1);
            r_acc <= r_acc | w_new_row;
          end
        end
        DONE: begin
          r_ptr     <= '0;
          r_gen     <= r_gen + GEN_W'(1);
          r_extinct <= ~|r_acc;
        end
        default: r_ptr <= '0;
      endcase
    end
  end

  assign extinct   = r_extinct;
  assign gen_count = r_gen;

endmodule

// File: tb/tb_gen_sequencer.sv
// Directed bench for gen_sequencer against a 1-cycle-latency 8x8 board memory.
module tb_gen_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, extinct;
  logic [7:0] gen_count;
  logic       mem_req;
  logic       mem_gnt = 1'b1;
  logic       rd_en, wr_en;
  logic [2:0] rd_addr, wr_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] wr_data;

  logic [7:0]  mem [8];
  logic        ld = 1'b0;
  logic [63:0] ld_val = '0;

  int n_pass = 0, n_total = 0;
  int n_done = 0, n_both = 0, n_nognt = 0, n_wdata = 0;

  gen_sequencer #(.ROWS(8), .ADDR_W(3), .GEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .extinct(extinct), .gen_count(gen_count), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++) mem[i] <= ld_val[8*i +: 8];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(posedge clk) begin
    #1;
    if (done) n_done++;
    if (rd_en && wr_en) n_both++;
    if (!mem_gnt && (rd_en || wr_en)) n_nognt++;
    if (!wr_en && (wr_data != 8'h00)) n_wdata++;
  end

  function automatic logic [63:0] board();
    logic [63:0] b;
    for (int i = 0; i < 8; i++) b[8*i +: 8] = mem[i];
    return b;
  endfunction

  task automatic load_board(input logic [63:0] b);
    ld_val = b;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Start one generation; optional grant stalls and a second start; returns start->done cycles.
  task automatic run_gen(input int ld_at, input int ld_len, input int wr_at, input int wr_len,
                         input int restart_at, output int cyc);
    start = 1'b1;
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start   = (n == restart_at);
      mem_gnt = !((n >= ld_at && n < ld_at + ld_len) || (n >= wr_at && n < wr_at + wr_len));
      if (done) begin
        cyc = n;
        break;
      end
    end
    start   = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({busy, done, extinct, mem_req, rd_en, wr_en} !== 6'b0)
      $display("FAIL reset_ctrl got=%b want=000000", {busy, done, extinct, mem_req, rd_en, wr_en});
    else n_pass++;
    n_total++;
    if (gen_count !== 8'd0) $display("FAIL reset_gen got=%0d want=0", gen_count);
    else n_pass++;
    n_total++;
    if (wr_data !== 8'h00) $display("FAIL reset_wdata got=%h want=00", wr_data);
    else n_pass++;
  endtask

  task automatic test_blinker();
    int cyc;
    do_reset();
    load_board(64'h00000000_1C000000);
    run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (cyc !== 19) $display("FAIL blinker_latency got=%0d want=19", cyc);
    else n_pass++;
    n_total++;
    if (board() !== 64'h00000008_08080000)
      $display("FAIL blinker_board got=%h want=%h", board(), 64'h00000008_08080000);
    else n_pass++;
    n_total++;
    if (gen_count !== 8'd1 || extinct !== 1'b0 || busy !== 1'b0)
      $display("FAIL blinker_status got gen=%0d ext=%b busy=%b want gen=1 ext=0 busy=0",
               gen_count, extinct, busy);
    else n_pass++;
  endtask

  task automatic test_still_life();
    int cyc;
    do_reset();
    load_board(64'h00000018_18000000);
    for (int k = 0; k < 3; k++) begin
      run_gen(0, 0, 0, 0, 0, cyc);
      n_total++;
      if (board() !== 64'h00000018_18000000 || extinct !== 1'b0)
        $display("FAIL still_board[%0d] got=%h ext=%b want=%h ext=0", k, board(), extinct,
                 64'h00000018_18000000);
      else n_pass++;
    end
    n_total++;
    if (gen_count !== 8'd3) $display("FAIL still_gen got=%0d want=3", gen_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    load_board(64'h00000000_00000083);
    run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (board() !== 64'h01000000_00000101)
      $display("FAIL wrap_gen1 got=%h want=%h", board(), 64'h01000000_00000101);
    else n_pass++;
    run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (board() !== 64'h00000000_00000083)
      $display("FAIL wrap_gen2 got=%h want=%h", board(), 64'h00000000_00000083);
    else n_pass++;
  endtask

  task automatic test_extinct_restart();
    int cyc, d0;
    do_reset();
    load_board(64'h00000000_00000001);
    d0 = n_done;
    run_gen(0, 0, 0, 0, 5, cyc);
    repeat (30) @(negedge clk);
    n_total++;
    if (cyc !== 19) $display("FAIL restart_latency got=%0d want=19", cyc);
    else n_pass++;
    n_total++;
    if (n_done - d0 !== 1) $display("FAIL restart_done_count got=%0d want=1", n_done - d0);
    else n_pass++;
    n_total++;
    if (board() !== 64'h0 || extinct !== 1'b1 || gen_count !== 8'd1 || busy !== 1'b0)
      $display("FAIL extinct_status got board=%h ext=%b gen=%0d busy=%b want 0 1 1 0",
               board(), extinct, gen_count, busy);
    else n_pass++;
  endtask

  task automatic test_grant_stall();
    int cyc;
    do_reset();
    load_board(64'h00000000_1C000000);
    run_gen(3, 3, 16, 2, 0, cyc);
    n_total++;
    if (cyc !== 24) $display("FAIL stall_latency got=%0d want=24", cyc);
    else n_pass++;
    n_total++;
    if (board() !== 64'h00000008_08080000)
      $display("FAIL stall_board got=%h want=%h", board(), 64'h00000008_08080000);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    logic saw_wr4;
    do_reset();
    load_board(64'h00000000_1C000000);
    start = 1'b1;
    saw_wr4 = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 15) begin
        saw_wr4 = wr_en && (wr_addr == 3'd4);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    n_total++;
    if (saw_wr4 !== 1'b1) $display("FAIL midwr_ptr got=%b want=1", saw_wr4);
    else n_pass++;
    n_total++;
    if ({busy, done, extinct, mem_req, rd_en, wr_en} !== 6'b0 || gen_count !== 8'd0 ||
        wr_data !== 8'h00 || rd_addr !== 3'd0 || wr_addr !== 3'd0)
      $display("FAIL midwr_reset got ctrl=%b gen=%0d wd=%h want all zero",
               {busy, done, extinct, mem_req, rd_en, wr_en}, gen_count, wr_data);
    else n_pass++;
    reset = 1'b0;
    n_total++;
    if (mem[2] !== 8'h08 || mem[3] !== 8'h08 || mem[5] !== 8'h00)
      $display("FAIL midwr_partial got r2=%h r3=%h r5=%h want 08 08 00", mem[2], mem[3], mem[5]);
    else n_pass++;
    @(negedge clk);
    load_board(64'h00000000_1C000000);
    run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (cyc !== 19 || board() !== 64'h00000008_08080000 || gen_count !== 8'd1)
      $display("FAIL midwr_rerun got cyc=%0d board=%h gen=%0d want 19 %h 1",
               cyc, board(), gen_count, 64'h00000008_08080000);
    else n_pass++;
  endtask

  task automatic test_gen_wrap();
    int cyc;
    do_reset();
    load_board(64'h0);
    for (int k = 0; k < 255; k++) run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (gen_count !== 8'd255) $display("FAIL genwrap_255 got=%0d want=255", gen_count);
    else n_pass++;
    run_gen(0, 0, 0, 0, 0, cyc);
    n_total++;
    if (gen_count !== 8'd0 || extinct !== 1'b1)
      $display("FAIL genwrap_0 got gen=%0d ext=%b want gen=0 ext=1", gen_count, extinct);
    else n_pass++;
  endtask

  task automatic test_bus_rules();
    n_total++;
    if (n_both !== 0) $display("FAIL rd_wr_overlap got=%0d want=0", n_both);
    else n_pass++;
    n_total++;
    if (n_nognt !== 0) $display("FAIL access_without_gnt got=%0d want=0", n_nognt);
    else n_pass++;
    n_total++;
    if (n_wdata !== 0) $display("FAIL wdata_idle_nonzero got=%0d want=0", n_wdata);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_blinker();
    test_still_life();
    test_wrap();
    test_extinct_restart();
    test_grant_stall();
    test_reset_mid_write();
    test_gen_wrap();
    test_bus_rules();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
